// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   NOP / HALT_INSTR : special instruction encodings
//   PC_STEP          : byte increment between sequential instructions
//   if_state_t       : run-control states of the fetch stage
package mips_pkg;
  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} if_state_t;
endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port, one
// combinational read port. Contents are never reset.
//   i_clk            : clock
//   i_we             : write enable
//   i_waddr/i_wdata  : write word index / data
//   i_raddr          : read word index
//   o_rdata          : read data (combinational)
module instruction_memory #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);
  logic [31:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, run-control FSM (IDLE -> RUN -> DONE) and the
// IF/ID pipeline register, fronting a loadable instruction memory.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start               : leave IDLE, fetch from PC 0
//   i_load_en/addr/data   : program-load write (IDLE only)
//   i_stall               : hold PC and IF/ID
//   i_halt                : debug freeze of all state
//   i_jump/i_jump_address : taken jump resolved in ID
//   o_instruction, o_pc   : IF/ID instruction and its PC+4
//   o_done                : HALT word fetched, sticky until reset
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_load_en,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_jump,
  input  logic [31:0] i_jump_address,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_done
);
  if_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_opc;
  logic        r_done;

  logic [31:0] w_word;
  logic [31:0] w_pc_next;
  logic        w_we;
  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic        w_unused;

  assign w_we      = i_load_en && (r_state == IDLE);
  assign w_pc_next = r_pc + PC_STEP;
  assign w_unused  = ^{i_load_addr[31:IDX_W+2], i_load_addr[1:0]};

  instruction_memory #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_imem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (i_load_addr[IDX_W+1:2]),
    .i_wdata (i_load_data),
    .i_raddr (r_pc[IDX_W+1:2]),
    .o_rdata (w_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_pc    <= 32'd0;
      r_instr <= NOP;
      r_opc   <= 32'd0;
      r_done  <= 1'b0;
    end else if (!i_halt) begin
      case (r_state)
        IDLE: begin
          r_pc    <= 32'd0;
          r_instr <= NOP;
          r_opc   <= 32'd0;
          if (i_start) r_state <= RUN;
        end
        RUN: begin
          if (i_stall) begin
            // Hold everything; a concurrent jump is re-issued by ID later.
          end else if (i_jump) begin
            // Flush the wrong-path word; o_pc keeps its last value.
            r_pc    <= i_jump_address;
            r_instr <= NOP;
          end else if (w_word == HALT_INSTR) begin
            // Pass HALT down once and park the PC on it.
            r_instr <= HALT_INSTR;
            r_opc   <= w_pc_next;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_instr <= w_word;
            r_opc   <= w_pc_next;
            r_pc    <= w_pc_next;
          end
        end
        DONE: r_instr <= NOP;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_instruction = r_instr;
  assign o_pc          = r_opc;
  assign o_done        = r_done;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset, start, load_en, stall, halt, jump;
  logic [31:0] load_addr, load_data, jump_address;
  logic [31:0] instr, pc;
  logic        done;

  always #5 clk = ~clk;

  instruction_fetch #(.MEM_DEPTH(256)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_load_en      (load_en),
    .i_load_addr    (load_addr),
    .i_load_data    (load_data),
    .i_stall        (stall),
    .i_halt         (halt),
    .i_jump         (jump),
    .i_jump_address (jump_address),
    .o_instruction  (instr),
    .o_pc           (pc),
    .o_done         (done)
  );

  typedef struct {
    logic        rst, st, ld;
    logic [31:0] laddr, ldata;
    logic        stl, hlt, jmp;
    logic [31:0] jaddr;
    logic [31:0] e_instr, e_pc;
    logic        e_done;
  } vec_t;

  localparam logic [31:0] H = 32'hFFFF_FFFF;
  localparam int NV = 32;

  vec_t tbl [NV];
  int   applied = 0;
  int   errors  = 0;

  function automatic vec_t mk(logic rst, logic st, logic ld, logic [31:0] la, logic [31:0] ldt,
                              logic stl, logic hlt, logic jmp, logic [31:0] ja,
                              logic [31:0] ei, logic [31:0] ep, logic ed);
    vec_t v;
    v.rst = rst; v.st = st; v.ld = ld; v.laddr = la; v.ldata = ldt;
    v.stl = stl; v.hlt = hlt; v.jmp = jmp; v.jaddr = ja;
    v.e_instr = ei; v.e_pc = ep; v.e_done = ed;
    return v;
  endfunction

  // Drive one vector before a rising edge, compare just after it.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    reset = v.rst; start = v.st; load_en = v.ld; load_addr = v.laddr; load_data = v.ldata;
    stall = v.stl; halt = v.hlt; jump = v.jmp; jump_address = v.jaddr;
    @(posedge clk);
    #1;
    applied++;
    if (instr !== v.e_instr || pc !== v.e_pc || done !== v.e_done) begin
      errors++;
      $display("FAIL %s: got instr=%h pc=%h done=%b, want instr=%h pc=%h done=%b",
               name, instr, pc, done, v.e_instr, v.e_pc, v.e_done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    stall = 1'b0; halt = 1'b0; jump = 1'b0; jump_address = '0;

    //           rst st ld laddr      ldata     stl hlt jmp jaddr      e_instr   e_pc       e_done
    tbl[0]  = mk(1, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h0,    32'h0,     0); // reset
    tbl[1]  = mk(0, 0, 1, 32'h00,    32'h11,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0);
    tbl[2]  = mk(0, 0, 1, 32'h04,    32'h22,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0);
    tbl[3]  = mk(0, 0, 1, 32'h0B,    32'h33,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0); // low bits ignored
    tbl[4]  = mk(0, 0, 1, 32'h20,    32'hAA,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0);
    tbl[5]  = mk(0, 0, 1, 32'h24,    32'hBB,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0);
    tbl[6]  = mk(0, 0, 1, 32'h28,    H,        0, 0, 0, 32'h0,     32'h0,    32'h0,     0);
    tbl[7]  = mk(0, 1, 1, 32'h0C,    32'h44,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0); // load+start
    tbl[8]  = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h11,   32'h4,     0);
    tbl[9]  = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h22,   32'h8,     0);
    tbl[10] = mk(0, 0, 0, 32'h0,     32'h0,    1, 0, 0, 32'h0,     32'h22,   32'h8,     0); // stall
    tbl[11] = mk(0, 0, 0, 32'h0,     32'h0,    1, 0, 0, 32'h0,     32'h22,   32'h8,     0);
    tbl[12] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h33,   32'hC,     0);
    tbl[13] = mk(0, 0, 0, 32'h0,     32'h0,    0, 1, 0, 32'h0,     32'h33,   32'hC,     0); // freeze
    tbl[14] = mk(0, 0, 0, 32'h0,     32'h0,    0, 1, 1, 32'h80,    32'h33,   32'hC,     0);
    tbl[15] = mk(0, 0, 0, 32'h0,     32'h0,    1, 1, 0, 32'h0,     32'h33,   32'hC,     0);
    tbl[16] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h44,   32'h10,    0);
    tbl[17] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 1, 32'h20,    32'h0,    32'h10,    0); // jump bubble
    tbl[18] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'hAA,   32'h24,    0);
    tbl[19] = mk(0, 0, 0, 32'h0,     32'h0,    1, 0, 1, 32'h0,     32'hAA,   32'h24,    0); // jump+stall
    tbl[20] = mk(0, 0, 1, 32'h28,    32'h55,   0, 0, 0, 32'h0,     32'hBB,   32'h28,    0); // RUN load dropped
    tbl[21] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 1, 32'h28,    32'h0,    32'h28,    0); // HALT flushed
    tbl[22] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     H,        32'h2C,    1); // HALT fetched
    tbl[23] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h0,    32'h2C,    1);
    tbl[24] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 1, 32'h0,     32'h0,    32'h2C,    1); // jump in DONE
    tbl[25] = mk(0, 0, 1, 32'h00,    32'h99,   0, 0, 0, 32'h0,     32'h0,    32'h2C,    1); // DONE load dropped
    tbl[26] = mk(1, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h0,    32'h0,     0); // reset from DONE
    tbl[27] = mk(0, 1, 1, 32'h04,    32'h66,   0, 0, 0, 32'h0,     32'h0,    32'h0,     0);
    tbl[28] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h11,   32'h4,     0); // mem[0] kept
    tbl[29] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h66,   32'h8,     0);
    tbl[30] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 1, 32'h401,   32'h0,    32'h8,     0); // wrap+misalign
    tbl[31] = mk(0, 0, 0, 32'h0,     32'h0,    0, 0, 0, 32'h0,     32'h11,   32'h405,   0);

    for (int i = 0; i < NV; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Freeze while HALT sits in IF/ID: HALT must stay visible, then drain to NOP.
    apply(mk(0,0,0,0,0, 0,0,1,32'h28, 32'h0, 32'h405, 0), "seq_jmp_halt");
    apply(mk(0,0,0,0,0, 0,0,0,32'h0,  H,     32'h2C,  1), "seq_halt_in");
    apply(mk(0,0,0,0,0, 0,1,0,32'h0,  H,     32'h2C,  1), "seq_frz1");
    apply(mk(0,0,0,0,0, 0,1,0,32'h0,  H,     32'h2C,  1), "seq_frz2");
    apply(mk(0,0,0,0,0, 0,0,0,32'h0,  32'h0, 32'h2C,  1), "seq_drain");

    // Stall in DONE is ignored and must not restart fetch.
    apply(mk(0,0,0,0,0, 1,0,0,32'h0,  32'h0, 32'h2C,  1), "seq_done_stall");

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction Fetch (IF) stage of the 5-stage MIPS pipeline, located directly upstream of `instruction_decode`.
- Holds the PC and a loadable instruction memory.
- Drives the IF/ID pipeline register (`o_instruction`, `o_pc`).
- Obeys the hazard unit's stall, ID-resolved jumps and the debug freeze.
- Runs a small run-control FSM: program load → run → done on a HALT word.

## Interface
Parameters:
- `MEM_DEPTH`, 256: instruction memory size in 32-bit words (power of two).
- `IDX_W`, `$clog2(MEM_DEPTH)`: word-index width.

Ports:
- `i_clk` input 1: single clock, all state on posedge.
- `i_reset` input 1: reset is synchronous and active-high.
- `i_start` input 1: leave IDLE and begin fetching from PC 0.
- `i_load_en` input 1: program-load write strobe, honoured only in IDLE.
- `i_load_addr` input 32: byte address of the word to write.
- `i_load_data` input 32: instruction word to write.
- `i_stall` input 1: hazard-unit stall; hold PC and IF/ID.
- `i_halt` input 1: debug freeze; hold all state.
- `i_jump` input 1: ID resolved a taken jump/branch this cycle.
- `i_jump_address` input 32: jump target, byte address.
- `o_instruction` output 32: IF/ID instruction.
- `o_pc` output 32: IF/ID PC+4 of `o_instruction`, used by ID for links and targets.
- `o_done` output 1: HALT word has been fetched; high until reset.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: PC=0, IF/ID holds NOP, loads allowed. Moves to RUN on `i_start`.
  - RUN: fetching. Moves to DONE when the fetched word equals `HALT_INSTR`.
  - DONE: exited only by `i_reset`.
- Memory write, IDLE only: `mem[i_load_addr[IDX_W+1:2]] <= i_load_data`.
  - `i_load_addr[1:0]` is ignored.
  - Writes in RUN and DONE are dropped.
- Memory read is combinational: `word = mem[pc[IDX_W+1:2]]`. PC bits above the index are ignored, so PC wraps modulo `MEM_DEPTH*4`.
- RUN update priority, highest first (each edge):
  1. `i_reset`.
  2. `i_halt`: PC, IF/ID and state are all held.
  3. `i_stall`: PC and IF/ID are held. A concurrent `i_jump` is ignored, because ID re-asserts it after the stall clears.
  4. `i_jump`: `PC <= i_jump_address`, `o_instruction <= NOP`, `o_pc <= o_pc` (held). This flushes the wrong-path word; there is no delay slot.
  5. Normal: `o_instruction <= word`, `o_pc <= PC+4`, `PC <= PC+4`.
- HALT handling in RUN (normal path, `word == HALT_INSTR`):
  - `o_instruction <= HALT_INSTR` for exactly one cycle, so downstream can drain.
  - `o_pc <= PC+4`; PC is not advanced.
  - `state <= DONE`.
  - A HALT word on a jump-flushed or stalled cycle does not trigger DONE.
- DONE: `o_instruction <= NOP` every cycle, `o_done = 1`, PC frozen. `i_jump`, `i_stall` and `i_load_en` are ignored; `i_halt` still freezes.
- PC arithmetic is 32-bit unsigned with natural wrap. Misaligned jump targets are truncated to a word index by the read.

## Timing
- Reset values: PC=0, `o_instruction`=0 (NOP), `o_pc`=0, `o_done`=0, state=IDLE. Memory contents are preserved.
- Start sequence: `i_start` sampled at edge N moves the FSM to RUN. Edge N+1 gives `o_instruction`=mem[0] and `o_pc`=4. Each following unstalled edge produces one instruction.
- Same-cycle load and start: `i_load_en` together with `i_start` in IDLE performs the write and the start. The written word is visible to the first fetch.
- Jump latency: `i_jump` at edge N gives a NOP in IF/ID after N. The target instruction appears after edge N+1, so a jump costs one bubble.
- Halt latency: `o_done` rises on the edge where HALT enters IF/ID.
- Reset mid-RUN or mid-DONE returns to IDLE on that edge. Loaded program memory is kept.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP` (32'h0) and `HALT_INSTR` (32'hFFFF_FFFF).
  - The IF state enum {IDLE, RUN, DONE}.
  - `PC_STEP` (4).
- Sub-module `instruction_memory`, parameterised by `MEM_DEPTH`: one synchronous write port and one combinational read port. Not reset.
- PC register, FSM and IF/ID register live in `instruction_fetch`.

## Test plan
- Sequential fetch: load words 0x11,0x22,0x33 at addrs 0,4,8, then start → `o_instruction` 0x11/0x22/0x33 with `o_pc` 4/8/12 on consecutive cycles.
- Stall: assert `i_stall` for 2 cycles while 0x22 is in IF/ID → 0x22 and `o_pc`=8 held for 2 extra cycles, then 0x33.
- Jump: `i_jump`=1, `i_jump_address`=0x20 (mem[8]=0xAA) → next IF/ID NOP, then 0xAA with `o_pc`=0x24. Repeat with `i_stall`=1 too → jump ignored.
- Halt word: HALT at addr 12 → HALT in IF/ID once with `o_pc`=16 and `o_done`=1, then NOP forever. A later `i_jump` has no effect.
- Debug freeze: `i_halt` for 3 cycles mid-RUN → all outputs and PC unchanged, then the sequence resumes in order.
- Reset and load rules: `i_reset` while in DONE → IDLE, outputs 0, mem[0] intact, restart refetches 0x11. A load attempted in RUN leaves the target word unchanged.
